div_seq_4ch: RTL and testbench
==============================

Name: div_seq_4ch

Overview:
- Four-channel front-end scheduler for the shared 29-bit weight divider (dividend/divisor in, 16-bit weight_pre ± quotient out).
- Arbitrates per-channel update requests round-robin and latches the winner's operands.
- Drives the divider's load/enable protocol, captures its result and publishes per-channel 16-bit weights to the 4-channel delay datapath.

Parameters:
- LOAD_CYC, 2, cycles div_en held low with operands stable before a run.
- RUN_CYC, 33, cycles div_en held high for the iterative divide.
- GAP_CYC, 2, cycles div_en held low between run and commit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  4  per-channel update request; level, held until matching ack
- ack  out  4  one-cycle pulse: channel request accepted, operands latched
- dividend_in  in  116  4x29 signed two's-complement dividends, ch0 at [28:0]
- divisor_in  in  116  4x29 unsigned divisors, ch0 at [28:0]
- weight_pre_in  in  64  4x16 base weights, ch0 at [15:0]
- div_dividend  out  29  to divider dividend
- div_divisor  out  29  to divider divisor
- div_weight_pre  out  16  to divider weight_pre
- div_en  out  1  to divider enable
- div_result  in  16  from divider result
- weight  out  64  4x16 published weights, ch0 at [15:0]
- weight_vld  out  4  one-cycle pulse: channel weight updated this cycle
- div0_err  out  4  sticky per-channel flag: divisor==0 request seen
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1), all registers cleared:
  - state=IDLE, div_en=0, div_* operands=0, weight=0, weight_vld=0, ack=0, div0_err=0, rr pointer=ch0.
  - Reset mid-run aborts the run; no weight_vld is issued for that channel.
- Arbitration in IDLE:
  - If any req bit is set, grant the first set bit at or after the rr pointer, wrapping 3->0.
  - Same cycle: pulse ack[g], latch the channel's dividend/divisor/weight_pre into the div_* registers, set rr pointer = g+1 mod 4.
  - The requester may drop req or change operands from the next cycle; latched values are unaffected.
- Divisor zero:
  - Divider is not started. State goes directly to IDLE next cycle.
  - weight[g] <= latched weight_pre with a single weight_vld[g] pulse; div0_err[g] <= 1.
  - div0_err clears only on reset.
- FSM and div_en:
  - IDLE: div_en=0.
  - LOAD: LOAD_CYC cycles, div_en=0.
  - RUN: RUN_CYC cycles, div_en=1.
  - GAP: GAP_CYC cycles, div_en=0.
  - COMMIT: 1 cycle, div_en=1. The divider transfers weight_pre±quotient to div_result at the end of this cycle.
  - CAPTURE: 1 cycle, div_en=0. weight[g] <= div_result, weight_vld[g]=1. Next state IDLE.
  - One cycle per state-counter tick; a down-counter sized for the largest parameter.
- div_* operands must stay constant from grant through CAPTURE; the divider re-samples them during low-enable phases.
- Latency: grant to weight_vld = 1+LOAD_CYC+RUN_CYC+GAP_CYC+1+1 = 40 cycles at defaults.
  - Next grant is possible in the cycle after CAPTURE (IDLE evaluates req).
  - Back-to-back service period = 41 cycles.
- Simultaneous events:
  - req asserted during a run is held pending and arbitrated in IDLE.
  - A req[g] still high after ack (not yet dropped) is treated as a new request: it re-qualifies in round-robin order, after the other pending channels.
- Widths:
  - Dividend is passed unmodified, sign included; the divider handles sign and magnitude.
  - weight is a straight 16-bit copy of div_result with no saturation.
- Only one weight_vld bit may be high in any cycle. ack and weight_vld are never high in the same cycle.

Test Plan:
- Single request, reset, then req[0] with dividend=100, divisor=7, weight_pre=1000: ack[0] at T0, div_en high for cycles T0+3..T0+35 and T0+38, weight_vld[0] at T0+40 with weight[15:0]=1014.
- Negative dividend on ch2 (dividend=-100, divisor=7, weight_pre=1000): weight[47:32]=986, only weight_vld[2] pulses, other channels unchanged.
- All four req high simultaneously with the pointer at ch0: acks in order 0,1,2,3, spaced 41 cycles; each weight correct; a re-held req[0] is served after ch3.
- Divisor=0 on ch1 with weight_pre=500: div_en never rises, weight_vld[1] pulses 1 cycle after ack, weight[31:16]=500, div0_err[1]=1 and stays set.
- Assert rst at RUN cycle 10 on ch3: all outputs zero immediately, no weight_vld; after release a fresh req[3] completes normally in 40 cycles.
- Operands on ch0 changed the cycle after ack: div_dividend/div_divisor/div_weight_pre hold the original values until CAPTURE, and the result matches the original operands.

Source files
------------

// File: rtl/div_seq_4ch.sv
// Four-channel round-robin scheduler in front of the shared iterative weight divider.
// Latches the winner's operands, sequences div_en through load/run/gap/commit, and publishes the result.
module div_seq_4ch #(
  parameter int LOAD_CYC = 2,
  parameter int RUN_CYC  = 33,
  parameter int GAP_CYC  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  input  logic [115:0] dividend_in,
  input  logic [115:0] divisor_in,
  input  logic [63:0]  weight_pre_in,
  output logic [28:0]  div_dividend,
  output logic [28:0]  div_divisor,
  output logic [15:0]  div_weight_pre,
  output logic         div_en,
  input  logic [15:0]  div_result,
  output logic [63:0]  weight,
  output logic [3:0]   weight_vld,
  output logic [3:0]   div0_err,
  output logic         busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;
  localparam logic [2:0] CAPTURE = 3'd5;

  localparam int MAX_LG  = (LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC;
  localparam int MAX_CYC = (RUN_CYC > MAX_LG) ? RUN_CYC : MAX_LG;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rr;
  logic [1:0]       ch;
  logic             zero_div;
  logic             gnt_vld;
  logic [1:0]       gnt;
  logic [1:0]       idx;

  // Scan from highest offset down so the first set bit at/after rr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = rr;
    idx     = rr;
    for (int i = 3; i >= 0; i--) begin
      idx = rr + 2'(i);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  assign div_en = (state == RUN) || (state == COMMIT);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rr             <= 2'd0;
      ch             <= 2'd0;
      zero_div       <= 1'b0;
      ack            <= 4'b0;
      div_dividend   <= '0;
      div_divisor    <= '0;
      div_weight_pre <= '0;
      weight         <= '0;
      weight_vld     <= 4'b0;
      div0_err       <= 4'b0;
    end else begin
      ack        <= 4'b0;
      weight_vld <= 4'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ack[gnt]       <= 1'b1;
            ch             <= gnt;
            rr             <= gnt + 2'd1;
            div_dividend   <= dividend_in[29*gnt +: 29];
            div_divisor    <= divisor_in[29*gnt +: 29];
            div_weight_pre <= weight_pre_in[16*gnt +: 16];
            // A zero divisor bypasses the divider and republishes weight_pre.
            if (divisor_in[29*gnt +: 29] == 29'd0) begin
              zero_div      <= 1'b1;
              div0_err[gnt] <= 1'b1;
              state         <= CAPTURE;
            end else begin
              zero_div <= 1'b0;
              state    <= LOAD;
              cnt      <= CNT_W'(LOAD_CYC);
            end
          end
        end
        // The ack cycle plus LOAD_CYC further low-enable cycles.
        LOAD: begin
          if (cnt == '0) begin
            state <= RUN;
            cnt   <= CNT_W'(RUN_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= CNT_W'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= COMMIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COMMIT: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          weight[16*ch +: 16] <= zero_div ? div_weight_pre : div_result;
          weight_vld[ch]      <= 1'b1;
          state               <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_4ch.sv
// Bench for div_seq_4ch: vector table, multi-cycle corner sequences and random traffic
// against a behavioural divider and a per-channel weight/error model.
module tb_div_seq_4ch;

  localparam int RUN_CYC = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0;
  logic [3:0]   ack;
  logic [115:0] dividend_in = '0;
  logic [115:0] divisor_in = '0;
  logic [63:0]  weight_pre_in = '0;
  logic [28:0]  div_dividend;
  logic [28:0]  div_divisor;
  logic [15:0]  div_weight_pre;
  logic         div_en;
  logic [15:0]  div_result;
  logic [63:0]  weight;
  logic [3:0]   weight_vld;
  logic [3:0]   div0_err;
  logic         busy;

  div_seq_4ch dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .dividend_in(dividend_in), .divisor_in(divisor_in), .weight_pre_in(weight_pre_in),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_weight_pre(div_weight_pre),
    .div_en(div_en), .div_result(div_result),
    .weight(weight), .weight_vld(weight_vld), .div0_err(div0_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected weights and sticky error flags, per channel.
  logic [15:0] mdl_w [4];
  logic [3:0]  mdl_err;

  function automatic logic [15:0] ref_w(logic [28:0] dvd, logic [28:0] dvs, logic [15:0] pre);
    int q;
    if (dvs == 29'd0) return pre;
    q = $signed({{3{dvd[28]}}, dvd}) / int'({3'b0, dvs});
    return pre + q[15:0];
  endfunction

  function automatic logic [63:0] mdl_vec();
    return {mdl_w[3], mdl_w[2], mdl_w[1], mdl_w[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Divider: samples operands while enable is low, publishes only at the commit pulse
  // (the first enabled cycle after RUN_CYC enabled cycles); garbage otherwise.
  int          hi_cnt;
  logic [28:0] s_dvd, s_dvs;
  logic [15:0] s_pre;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt     <= 0;
      div_result <= '0;
    end else if (div_en) begin
      if (hi_cnt == RUN_CYC) begin
        div_result <= ref_w(s_dvd, s_dvs, s_pre);
        hi_cnt     <= 0;
      end else begin
        hi_cnt     <= hi_cnt + 1;
        div_result <= 16'($urandom());
      end
    end else begin
      s_dvd <= div_dividend;
      s_dvs <= div_divisor;
      s_pre <= div_weight_pre;
    end
  end

  always @(negedge clk) begin
    if (!rst && (ack != 0 || weight_vld != 0)) begin
      n_cmp++;
      if ((ack != 0 && weight_vld != 0) || !$onehot0(ack) || !$onehot0(weight_vld)) begin
        n_bad++;
        $display("FAIL pulse_excl: ack=%b weight_vld=%b required one-hot and disjoint", ack, weight_vld);
      end
    end
  end

  task automatic set_ops(input int ch, input logic [28:0] dvd, input logic [28:0] dvs, input logic [15:0] pre);
    dividend_in[29*ch +: 29]  = dvd;
    divisor_in[29*ch +: 29]   = dvs;
    weight_pre_in[16*ch +: 16] = pre;
  endtask

  task automatic scramble();
    for (int k = 0; k < 4; k++) set_ops(k, 29'($urandom()), 29'($urandom()), 16'($urandom()));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ack"}, 64'(ack), 64'd0);
    check({tag, " weight"}, weight, 64'd0);
    check({tag, " weight_vld"}, 64'(weight_vld), 64'd0);
    check({tag, " div0_err"}, 64'(div0_err), 64'd0);
    check({tag, " busy_en"}, {62'd0, busy, div_en}, 64'd0);
    check({tag, " div_ops"}, {div_dividend, div_divisor[28:0] == 29'd0, div_weight_pre}, 64'd1 << 16);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mdl_w[k] = '0;
    mdl_err = '0;
  endtask

  // One isolated request; operands scrambled right after ack to prove they were latched.
  task automatic run_one(input int ch, input logic [28:0] dvd, input logic [28:0] dvs,
                         input logic [15:0] pre, input int exp_w, input string name);
    int t0, n_hi, first_hi, last_hi;
    bit got, stable;
    set_ops(ch, dvd, dvs, pre);
    req[ch] = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ack != 0) got = 1;
    end
    check({name, " ack"}, 64'(ack), 64'(4'b1 << ch));
    req[ch] = 1'b0;
    if (!got) return;
    t0 = cyc;
    scramble();
    got = 0; stable = 1; n_hi = 0; first_hi = -1; last_hi = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (div_en) begin
        n_hi++;
        if (first_hi < 0) first_hi = cyc - t0;
        last_hi = cyc - t0;
      end
      if (div_dividend !== dvd || div_divisor !== dvs || div_weight_pre !== pre) stable = 0;
      if (weight_vld != 0) got = 1;
    end
    mdl_w[ch] = ref_w(dvd, dvs, pre);
    if (dvs == 29'd0) mdl_err[ch] = 1'b1;
    check({name, " latency"}, 64'(cyc - t0), (dvs == 29'd0) ? 64'd1 : 64'd40);
    check({name, " weight_vld"}, 64'(weight_vld), 64'(4'b1 << ch));
    if (exp_w >= 0) check({name, " weight_slice"}, 64'(weight[16*ch +: 16]), 64'(exp_w));
    check({name, " weight_all"}, weight, mdl_vec());
    check({name, " div0_err"}, 64'(div0_err), 64'(mdl_err));
    check({name, " ops_stable"}, 64'(stable), 64'd1);
    check({name, " en_cycles"}, 64'(n_hi), (dvs == 29'd0) ? 64'd0 : 64'd34);
    if (dvs != 29'd0) check({name, " en_window"}, {32'(first_hi), 32'(last_hi)}, {32'd3, 32'd38});
  endtask

  typedef struct {
    int          ch;
    logic [28:0] dvd;
    logic [28:0] dvs;
    logic [15:0] pre;
    int          exp_w;
  } vec_t;

  vec_t vt [8];
  int   ack_t [5];
  int   ack_c [5];
  int   na, nv, nwv;

  initial begin
    vt[0] = '{0, 29'd100,        29'd7,          16'd1000,  1014};
    vt[1] = '{2, 29'h1FFFFF9C,   29'd7,          16'd1000,  986};
    vt[2] = '{1, 29'd50,         29'd0,          16'd500,   500};
    vt[3] = '{3, 29'd300000,     29'd1000,       16'd5,     305};
    vt[4] = '{0, 29'd1,          29'd1,          16'hFFFF,  0};
    vt[5] = '{2, 29'h0FFFFFFF,   29'h1FFFFFFF,   16'd7,     7};
    vt[6] = '{1, 29'h1FFFFC18,   29'd3,          16'd10,    16'hFEBD};
    vt[7] = '{3, 29'h10000000,   29'd1,          16'd42,    42};

    do_reset();
    for (int i = 0; i < 8; i++) run_one(vt[i].ch, vt[i].dvd, vt[i].dvs, vt[i].pre, vt[i].exp_w, $sformatf("vec%0d", i));
    repeat (5) @(negedge clk);
    check("div0_sticky", 64'(div0_err), 64'(4'b0010));

    // All four at once from pointer ch0; req[0] held through its first ack.
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, 29'(1000 * (k + 1)), 29'(k + 3), 16'(100 * k));
    req = 4'hF;
    na = 0; nv = 0;
    for (int i = 0; i < 300 && nv < 5; i++) begin
      @(negedge clk);
      if (ack != 0 && na < 5) begin
        ack_t[na] = cyc;
        ack_c[na] = 0;
        for (int k = 0; k < 4; k++) if (ack[k]) ack_c[na] = k;
        if (na > 0) req[ack_c[na]] = 1'b0;
        na++;
      end
      if (weight_vld != 0) begin
        for (int k = 0; k < 4; k++) if (weight_vld[k])
          check($sformatf("rr_weight ch%0d", k), 64'(weight[16*k +: 16]),
                64'(ref_w(29'(1000 * (k + 1)), 29'(k + 3), 16'(100 * k))));
        nv++;
      end
    end
    req = 4'b0;
    check("rr_acks", 64'(na), 64'd5);
    check("rr_order", {ack_c[0][3:0], ack_c[1][3:0], ack_c[2][3:0], ack_c[3][3:0], ack_c[4][3:0]},
          {4'd0, 4'd1, 4'd2, 4'd3, 4'd0});
    for (int k = 1; k < 5; k++) check($sformatf("rr_spacing%0d", k), 64'(ack_t[k] - ack_t[k-1]), 64'd41);

    // Reset in the middle of RUN on ch3.
    do_reset();
    set_ops(3, 29'd777, 29'd5, 16'd1234);
    req[3] = 1'b1;
    na = 0;
    for (int i = 0; i < 50 && na == 0; i++) begin
      @(negedge clk);
      if (ack[3]) na = 1;
    end
    check("abort ack", 64'(na), 64'd1);
    req[3] = 1'b0;
    repeat (12) @(negedge clk);
    check("abort in_run", 64'(div_en), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mdl_w[k] = '0;
    mdl_err = '0;
    nwv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (weight_vld != 0) nwv++;
    end
    check("abort no_vld", 64'(nwv), 64'd0);
    run_one(3, 29'd777, 29'd5, 16'd1234, 1389, "after_abort");

    // Random isolated traffic.
    for (int i = 0; i < 24; i++) begin
      int          ch;
      logic [28:0] dvs;
      ch  = $urandom_range(0, 3);
      dvs = ($urandom_range(0, 7) == 0) ? 29'd0 :
            ($urandom_range(0, 1) == 0) ? 29'($urandom_range(1, 5000)) : 29'($urandom());
      run_one(ch, 29'($urandom()), dvs, 16'($urandom()), -1, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
